if_id_stage: RTL and testbench

//  IF/ID pipeline stage of the 32-bit MIPS-style core; sits directly downstream of PC + IMEM.

---
 rtl/if_id_stage.sv | 124 ++++++++++++
 tb/tb_if_id_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a 2-entry skid buffer (MAIN + SKID) and synchronous flush.
// The fetch word is split into R/I fields when it is loaded, so decode reads every field straight from a flop.
module if_id_stage #(
    parameter logic [31:0] PC_INC    = 32'd1,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    output logic        if_ready,
    input  logic        flush,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_next,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [31:0] id_imm_sext,
    output logic [31:0] id_imm_zext,
    output logic [31:0] id_count
);

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t      state, state_d;
    logic [31:0] skid_pc, skid_instr;
    logic        acc, take;
    logic        main_load, skid_load;
    logic [31:0] main_pc_d, main_instr_d;

    // Both handshake flags come from the state register only, so id_ready never reaches if_ready.
    assign if_ready = (state != SKID);
    assign id_valid = (state != EMPTY);
    assign acc      = if_valid & if_ready;
    assign take     = id_valid & id_ready;

    always_comb begin
        state_d      = state;
        main_load    = 1'b0;
        skid_load    = 1'b0;
        main_pc_d    = if_pc;
        main_instr_d = if_instr;
        if (flush) begin
            // Squash: keep the PC, replace the instruction with a NOP so the fields decode to it.
            state_d      = EMPTY;
            main_load    = 1'b1;
            main_pc_d    = id_pc;
            main_instr_d = NOP_INSTR;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    state_d   = FULL;
                    main_load = 1'b1;
                end
                FULL: begin
                    if (take && acc) begin
                        main_load = 1'b1;
                    end else if (take) begin
                        state_d = EMPTY;
                    end else if (acc) begin
                        state_d   = SKID;
                        skid_load = 1'b1;
                    end
                end
                SKID: if (take) begin
                    state_d      = FULL;
                    main_load    = 1'b1;
                    main_pc_d    = skid_pc;
                    main_instr_d = skid_instr;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            skid_pc     <= 32'h0;
            skid_instr  <= 32'h0;
            id_count    <= 32'h0;
            id_pc       <= 32'h0;
            id_pc_next  <= PC_INC;
            id_instr    <= NOP_INSTR;
            id_opcode   <= NOP_INSTR[31:26];
            id_rs       <= NOP_INSTR[25:21];
            id_rt       <= NOP_INSTR[20:16];
            id_rd       <= NOP_INSTR[15:11];
            id_shamt    <= NOP_INSTR[10:6];
            id_funct    <= NOP_INSTR[5:0];
            id_imm_sext <= {{16{NOP_INSTR[15]}}, NOP_INSTR[15:0]};
            id_imm_zext <= {16'h0, NOP_INSTR[15:0]};
        end else begin
            state <= state_d;
            if (take)
                id_count <= id_count + 32'd1;
            if (skid_load) begin
                skid_pc    <= if_pc;
                skid_instr <= if_instr;
            end
            if (main_load) begin
                id_pc       <= main_pc_d;
                id_pc_next  <= main_pc_d + PC_INC;
                id_instr    <= main_instr_d;
                id_opcode   <= main_instr_d[31:26];
                id_rs       <= main_instr_d[25:21];
                id_rt       <= main_instr_d[20:16];
                id_rd       <= main_instr_d[15:11];
                id_shamt    <= main_instr_d[10:6];
                id_funct    <= main_instr_d[5:0];
                id_imm_sext <= {{16{main_instr_d[15]}}, main_instr_d[15:0]};
                id_imm_zext <= {16'h0, main_instr_d[15:0]};
            end
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: streaming, skid back-pressure, flush, field split, wrap, async reset.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid, flush, id_ready;
    logic [31:0] if_pc, if_instr;
    logic        if_ready, id_valid;
    logic [31:0] id_pc, id_pc_next, id_instr, id_imm_sext, id_imm_zext, id_count;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;

    int checks = 0;
    int errors = 0;

    if_id_stage dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_pc_next(id_pc_next), .id_instr(id_instr),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct),
        .id_imm_sext(id_imm_sext), .id_imm_zext(id_imm_zext), .id_count(id_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] imem(input logic [31:0] pc);
        return 32'hA500_0000 | (pc * 32'h0001_0101);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic rdy);
        if_valid = v;
        if_pc    = pc;
        if_instr = imem(pc);
        id_ready = rdy;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
        chk({tag, "_ifrdy"}, {31'h0, if_ready}, 32'h1);
        chk({tag, "_pc"},    id_pc,      32'h0);
        chk({tag, "_pcn"},   id_pc_next, 32'h1);
        chk({tag, "_instr"}, id_instr,   32'h0);
        chk({tag, "_cnt"},   id_count,   32'h0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        offer(1'b0, 32'h0, 1'b0);
        #12;
        chk_reset_vals("rst");
        chk("rst_imm", id_imm_sext, 32'h0);
        reset = 1'b0;

        // T1: stream pc 0..9 with decode always ready
        for (int i = 0; i < 10; i++) begin
            offer(1'b1, i, 1'b1);
            step();
            chk("t1_valid", {31'h0, id_valid}, 32'h1);
            chk("t1_pc",    id_pc,      i);
            chk("t1_pcn",   id_pc_next, i + 1);
            chk("t1_instr", id_instr,   imem(i));
            chk("t1_cnt",   id_count,   i);
        end
        offer(1'b0, 32'h0, 1'b1);
        step();
        chk("t1_drain", {31'h0, id_valid}, 32'h0);
        chk("t1_cnt10", id_count, 32'd10);

        // T2: pc 4 held in MAIN, pc 5 in SKID while decode stalls
        offer(1'b1, 32'd3, 1'b1); step();
        offer(1'b1, 32'd4, 1'b1); step();
        chk("t2_pc4", id_pc, 32'd4);
        offer(1'b1, 32'd5, 1'b0); step();
        chk("t2_ifrdy0", {31'h0, if_ready}, 32'h0);
        offer(1'b1, 32'd6, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t2_hold_pc",    id_pc,    32'd4);
            chk("t2_hold_instr", id_instr, imem(4));
            chk("t2_hold_vld",   {31'h0, id_valid}, 32'h1);
            chk("t2_hold_rdy",   {31'h0, if_ready}, 32'h0);
        end
        offer(1'b0, 32'd0, 1'b1); step();
        chk("t2_pc5",    id_pc,    32'd5);
        chk("t2_instr5", id_instr, imem(5));
        chk("t2_ifrdy1", {31'h0, if_ready}, 32'h1);
        step();
        chk("t2_empty", {31'h0, id_valid}, 32'h0);
        chk("t2_cnt",   id_count, 32'd13);

        // T3: flush while in SKID with a new offer
        offer(1'b1, 32'd20, 1'b0); step();
        offer(1'b1, 32'd21, 1'b0); step();
        chk("t3_skid", {31'h0, if_ready}, 32'h0);
        offer(1'b1, 32'd22, 1'b0); flush = 1'b1; step();
        flush = 1'b0;
        chk("t3_valid", {31'h0, id_valid}, 32'h0);
        chk("t3_instr", id_instr, 32'h0);
        chk("t3_ifrdy", {31'h0, if_ready}, 32'h1);
        chk("t3_pc",    id_pc,    32'd20);
        offer(1'b0, 32'd0, 1'b1); step();
        chk("t3_gone", {31'h0, id_valid}, 32'h0);
        chk("t3_cnt",  id_count, 32'd13);

        // T4: I-type and R-type field split
        if_valid = 1'b1; if_pc = 32'd30; if_instr = 32'h2009FFFC; id_ready = 1'b1; step();
        chk("t4_op",   {26'h0, id_opcode}, 32'h08);
        chk("t4_rs",   {27'h0, id_rs},     32'h0);
        chk("t4_rt",   {27'h0, id_rt},     32'h9);
        chk("t4_sext", id_imm_sext, 32'hFFFFFFFC);
        chk("t4_zext", id_imm_zext, 32'h0000FFFC);
        if_pc = 32'd31; if_instr = 32'h012A4020; step();
        chk("t4_rd",    {27'h0, id_rd},    32'h8);
        chk("t4_funct", {26'h0, id_funct}, 32'h20);
        chk("t4_rrs",   {27'h0, id_rs},    32'h9);
        chk("t4_rrt",   {27'h0, id_rt},    32'hA);
        chk("t4_shamt", {27'h0, id_shamt}, 32'h0);
        offer(1'b0, 32'd0, 1'b1); step();
        chk("t4_cnt", id_count, 32'd15);

        // T5: id_pc_next wraps at the top of the address space
        offer(1'b1, 32'hFFFFFFFF, 1'b1); step();
        chk("t5_pc",  id_pc,      32'hFFFFFFFF);
        chk("t5_pcn", id_pc_next, 32'h0);
        offer(1'b0, 32'd0, 1'b1); step();
        chk("t5_cnt", id_count, 32'd16);

        // T6: asynchronous reset mid-cycle while in SKID
        offer(1'b1, 32'd40, 1'b0); step();
        offer(1'b1, 32'd41, 1'b0); step();
        chk("t6_skid", {31'h0, if_ready}, 32'h0);
        #2 reset = 1'b1;
        #1 chk_reset_vals("t6");
        offer(1'b0, 32'd0, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk("t6_after", {31'h0, id_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
